multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the multi-cycle RV32I core. It sequences one instruction over 3–5 cycles through a shared ALU, a single unified memory port and the instruction register. From the IR opcode, the ALU zero flag and a memory-ready handshake it produces per-cycle datapath selects and write strobes. It replaces the purely combinational opcode decode used by the single-cycle core.

## Interface
- IGNORE_READY, default 0: when 1, `mem_ready` is treated as constantly 1 (zero-wait memory).
- clk       input   1  rising-edge clock
- rst_n     input   1  asynchronous, active-low reset
- op        input   7  opcode from instruction register (IR[6:0]); valid from DECODE onward
- zero      input   1  ALU zero flag
- mem_ready input   1  memory access completes this cycle
- PCWrite   output  1  PC register enable
- AdrSrc    output  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite   output  1  IR/OldPC load enable
- ResultSrc output  2  00 ALUOut, 01 read data, 10 ALU result
- ALUSrcA   output  2  00 PC, 01 OldPC, 10 rs1 data
- ALUSrcB   output  2  00 rs2 data, 01 ImmExt, 10 constant 4
- ALUOp     output  2  00 add, 01 subtract, 10 funct-decoded
- RegWrite  output  1  register-file write enable
- ImmSrc    output  2  00 I-type, 01 S-type, 10 B-type
- illegal_op output 1  one-cycle pulse on an unsupported opcode
- state     output  4  current state encoding, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, BEQ 10.
- Outputs not listed for a state are 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 1100011 → BEQ; 0010011 → EXECUTEI (macro only).
  - Any other op: illegal_op=1 and next state FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op=0000011 → MEMREAD, else → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held high until mem_ready=1 (inclusive), then → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero → FETCH.
- ImmSrc is combinational from op in every state: 0100011 → 01, 1100011 → 10, else 00.
- Unused state encodings return to FETCH on the next edge with all strobes 0.

## Timing
- Reset: state=0 (FETCH) immediately on rst_n low.
  - While rst_n=0: PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced 0.
  - Other outputs show FETCH values; ImmSrc follows op.
- First fetch is possible on the first rising edge after rst_n deasserts.
- Reset mid-instruction abandons it; no write strobe is issued after rst_n falls.
- Cycle counts with mem_ready=1 throughout: lw 5, sw 4, R/I-type 4, beq 3, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- PCWrite and IRWrite are Mealy on mem_ready, so they assert for exactly one edge per fetch.
- MEMREAD captures data on the edge where mem_ready=1.
- mem_ready outside memory states is ignored.
- Sampling point: op only at the DECODE→ and MEMADR→ transitions; zero only in BEQ.

## Configuration
- RV_ITYPE_ALU_EN defined: opcode 0010011 is legal and uses EXECUTEI → ALUWB.
- RV_ITYPE_ALU_EN undefined: EXECUTEI is not built; 0010011 takes the illegal path (illegal_op pulse, return to FETCH).

## Test plan
- lw, op=0000011, mem_ready=1: states 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. PCWrite/IRWrite=1 only in cycle 0.
- sw, op=0100011, mem_ready low for 3 cycles in MEMWRITE: MemWrite high for 4 consecutive cycles, AdrSrc=1, ImmSrc=01, then FETCH.
- beq, op=1100011: zero=1 gives PCWrite=1 in BEQ and ALUOp=01; zero=0 gives PCWrite=0. Total 3 cycles either way.
- R-type, op=0110011, FETCH mem_ready=0 for 2 cycles: IRWrite=0 during the wait, IRWrite=1 once. EXECUTER drives ALUOp=10, then ALUWB RegWrite=1.
- op=1111111: illegal_op=1 in DECODE, back to FETCH, no RegWrite or MemWrite. op=0010011: same result without the macro, reaches state 8 with it.
- rst_n pulled low in MEMWRITE with MemWrite=1: MemWrite drops to 0 asynchronously and state=0. After release, the next edge begins a fresh FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback through a shared datapath.
// Optional feature: define RV_ITYPE_ALU_EN to accept opcode 0010011 through EXECUTEI.
module multicycle_controller #(
    parameter bit IGNORE_READY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef RV_ITYPE_ALU_EN
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
`endif

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
`ifdef RV_ITYPE_ALU_EN
        EXECUTEI = 4'd8,
`endif
        BEQ      = 4'd10
    } state_t;

    state_t state_q, state_d;
    logic   ready;

    assign ready = IGNORE_READY ? 1'b1 : mem_ready;
    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;

        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            default:   ImmSrc = 2'b00;
        endcase

        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = ready;
                IRWrite   = ready;
                if (ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_BRANCH:         state_d = BEQ;
`ifdef RV_ITYPE_ALU_EN
                    OP_ITYPE:          state_d = EXECUTEI;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (ready) state_d = FETCH;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
`ifdef RV_ITYPE_ALU_EN
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
`endif
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // State is already FETCH during reset; only the strobes need suppressing.
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
